// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV32M unit sitting beside the EX-stage ALU.
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. The pipeline is stalled
// while the radix-2 shift-add multiplier or restoring divider iterates on one
// shared 33-bit adder. The result is then strobed for one cycle so EX can
// forward it alongside the ALU result.
// Build option: define EX_MULDIV_FAST_MUL_EN to resolve multiplies in a single
// cycle with a 33x33 signed combinational multiplier. Divides always iterate.
module ex_muldiv_seq #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
  localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [ITER_W-1:0] ONE_C   = ITER_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, next_state;

  // Iteration and operand state
  logic [ITER_W-1:0] cnt;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  // Multiply: {acc_hi, acc_lo} is the 64-bit product / multiplier register.
  // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out and
  //           quotient bits in.
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [2:0]        func_q;
  logic              neg_q;
  logic              rem_neg_q;

  // Two's-complement negate; wraps so that -(MIN_NEG) == MIN_NEG.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + ONE_X;
  endfunction

  // Decode of the op presented in IDLE
  logic            op_div;
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, div_special;
  logic            accept;
  logic            fast_mul;

  assign op_div   = i_func3[2];
  assign a_signed = (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
                    (i_func3 == 3'b100) || (i_func3 == 3'b110);
  assign b_signed = (i_func3 == 3'b001) || (i_func3 == 3'b100) ||
                    (i_func3 == 3'b110);
  assign sign_a   = a_signed & i_A[XLEN-1];
  assign sign_b   = b_signed & i_B[XLEN-1];
  assign a_abs    = sign_a ? negate(i_A) : i_A;
  assign b_abs    = sign_b ? negate(i_B) : i_B;
  assign div_zero = op_div && (i_B == '0);
  assign div_ovf  = op_div && !i_func3[0] && (i_A == MIN_NEG) && (i_B == '1);
  assign div_special = div_zero || div_ovf;
  assign accept   = (state == S_IDLE) && i_start && !i_flush;

`ifdef EX_MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_p;
  logic [XLEN-1:0]          fast_res;

  assign fast_mul = !op_div;
  assign fm_a     = {sign_a, i_A};
  assign fm_b     = {sign_b, i_B};
  assign fm_p     = fm_a * fm_b;
  assign fast_res = (i_func3 == 3'b000) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
`endif

  // Shared 33-bit adder: add multiplicand for multiply, trial subtract for divide
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   add_x, add_y;
  logic            add_ci;
  logic [XLEN+1:0] add_full;
  logic [XLEN:0]   add_sum;
  logic            add_carry;

  always_comb begin
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    add_x     = '0;
    add_y     = '0;
    add_ci    = 1'b0;
    if (func_q[2]) begin
      add_x  = div_shift;
      add_y  = ~{1'b0, b_mag};
      add_ci = 1'b1;
    end else begin
      add_x  = {1'b0, acc_hi};
      add_y  = acc_lo[0] ? {1'b0, a_mag} : '0;
    end
    add_full  = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_ci};
    add_sum   = add_full[XLEN:0];
    add_carry = add_full[XLEN+1];
  end

  // Sign fix-up and field select applied in FIX
  logic [XLEN-1:0] fix_res;

  always_comb begin
    fix_res = acc_lo;
    case (func_q)
      3'b000:                 fix_res = acc_lo;
      3'b001, 3'b010, 3'b011: fix_res = neg_q ? (~acc_hi + ((acc_lo == '0) ? ONE_X : '0))
                                              : acc_hi;
      3'b100, 3'b101:         fix_res = neg_q ? negate(acc_lo) : acc_lo;
      default:                fix_res = rem_neg_q ? negate(acc_hi) : acc_hi;
    endcase
  end

  // Value loaded into o_result when entering DONE
  logic [XLEN-1:0] spec_quo, spec_rem;
  logic [XLEN-1:0] done_res;

  always_comb begin
    spec_quo = div_zero ? '1 : MIN_NEG;
    spec_rem = div_zero ? i_A : '0;
    done_res = fix_res;
    if (state == S_IDLE) begin
`ifdef EX_MULDIV_FAST_MUL_EN
      done_res = fast_mul ? fast_res : (i_func3[1] ? spec_rem : spec_quo);
`else
      done_res = i_func3[1] ? spec_rem : spec_quo;
`endif
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; flush wins over everything except the DONE strobe
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = (div_special || fast_mul) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (i_flush)        next_state = S_IDLE;
        else if (cnt == '0) next_state = S_FIX;
      end
      S_FIX:   next_state = i_flush ? S_IDLE : S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // Stall: accepting cycle plus the whole iteration; released in reset and DONE
  always_comb begin
    o_stall = i_rst_n && (accept || (state == S_CALC) || (state == S_FIX));
  end

  // Datapath: operand latch, iteration, registered result strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      func_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      o_valid <= (next_state == S_DONE);
      if (next_state == S_DONE) o_result <= done_res;

      if (accept) begin
        func_q    <= i_func3;
        a_mag     <= a_abs;
        b_mag     <= b_abs;
        neg_q     <= sign_a ^ sign_b;
        rem_neg_q <= sign_a;
        cnt       <= '1;
        if (div_special) begin
          acc_hi <= spec_rem;
          acc_lo <= spec_quo;
        end else begin
          acc_hi <= '0;
          acc_lo <= op_div ? a_abs : b_abs;
        end
      end else if (state == S_CALC) begin
        cnt <= cnt - ONE_C;
        if (func_q[2]) begin
          acc_hi <= add_carry ? add_sum[XLEN-1:0] : div_shift[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], add_carry};
        end else begin
          {acc_hi, acc_lo} <= {add_sum, acc_lo[XLEN-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: the driver pushes hand-computed results
// and a monitor pops/compares them on every o_valid strobe.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] a, b;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

`ifdef EX_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 34;
`endif
  localparam int LAT_DIV = 34;
  localparam int LAT_SPC = 1;

  ex_muldiv_seq #(.XLEN(32), .ITER_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_func3 (func3),
    .i_A     (a),
    .i_B     (b),
    .i_flush (flush),
    .o_stall (stall),
    .o_valid (valid),
    .o_result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got result=%h, required no strobe", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.val) begin
          failures++;
          $display("FAIL %s result: got %h, required %h", e.nm, result, e.val);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Issue one op, hold start until the strobe, check latency and stall span
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] expv, input int lat);
    int got_lat;
    int nstall;
    exp_t e;
    e.nm  = nm;
    e.val = expv;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1;
    func3 = f;
    a     = av;
    b     = bv;
    got_lat = -1;
    nstall  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (valid) begin
        got_lat = c;
        break;
      end
      if (stall) nstall++;
      @(posedge clk); #1;
    end
    if (got_lat < 0) $display("FAIL %s timeout: got no strobe, required one within 100 cycles", nm);
    check({nm, " latency"}, got_lat, lat);
    check({nm, " stall_cycles"}, nstall, lat);
    check({nm, " stall_in_done"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({nm, " valid_one_cycle"}, {31'b0, valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    func3 = 3'b000;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid",  {31'b0, valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall",  {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Multiplies
    run_op("MUL 7*-3",          3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
    run_op("MULH min*min",      3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
    run_op("MULHU max*max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
    run_op("MULHSU -1*2",       3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_MUL);

    // Divide special cases
    run_op("DIV 100/0",         3'b100, 32'd100,      32'd0,        32'hFFFF_FFFF, LAT_SPC);
    run_op("REM 100/0",         3'b110, 32'd100,      32'd0,        32'd100,       LAT_SPC);
    run_op("DIV min/-1",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC);
    run_op("REM min/-1",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPC);

    // Iterative divides
    run_op("DIV -7/2",          3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_DIV);
    run_op("REM -7/2",          3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_DIV);
    run_op("DIVU max/2",        3'b101, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, LAT_DIV);
    run_op("REMU 7/3",          3'b111, 32'd7,        32'd3,        32'd1,         LAT_DIV);

    // Flush partway through an iterative divide: no strobe may follow
    @(posedge clk); #1;
    start = 1'b1;
    func3 = 3'b101;
    a     = 32'd1000;
    b     = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush stall_before", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush stall_after", {31'b0, stall}, 32'd0);
    check("flush valid_after", {31'b0, valid}, 32'd0);
    repeat (40) @(posedge clk);
    run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, LAT_MUL);

    // Asynchronous reset mid-iteration clears outputs at once
    @(posedge clk); #1;
    start = 1'b1;
    func3 = 3'b101;
    a     = 32'd1000;
    b     = 32'd7;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst valid",  {31'b0, valid}, 32'd0);
    check("async_rst result", result, 32'd0);
    check("async_rst stall",  {31'b0, stall}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    run_op("DIVU 1000/7 after reset", 3'b101, 32'd1000, 32'd7, 32'd142, LAT_DIV);

    repeat (3) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
